scan_sel_gen: RTL and testbench

Sequencer directly upstream of the 2-to-4 decoder. It generates the 2-bit select pair (`a`, `b`) that sweeps decoder outputs 0→1→2→3 with a programmable dwell time per position. It also supplies a valid qualifier, a busy flag and an end-of-sweep pulse. It runs either as a continuous scan (display/row multiplexing) or as a single sweep started by a handshake.

---
 rtl/scan_sel_gen_pkg.sv | 14 +
 rtl/scan_dwell_cnt.sv | 30 +++
 rtl/scan_sel_gen.sv | 193 +++++++++++++++++++
 tb/tb_scan_sel_gen.sv | 138 +++++++++++++
 4 files changed

// File: rtl/scan_sel_gen_pkg.sv
// Shared state encodings and default widths for the decoder select sequencer.
package scan_sel_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_t;

    localparam logic [1:0] LAST_POS      = 2'd3;
    localparam int         DEF_DWELL_W   = 8;
    localparam int         DEF_BLANK_CYC = 2;

endpackage

// File: rtl/scan_dwell_cnt.sv
// Loadable down-counter that saturates at zero; used for dwell and blank intervals.
module scan_dwell_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_r;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != {W{1'b0}})) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/scan_sel_gen.sv
// 2-bit select sweep generator for a 2-to-4 decoder with programmable dwell.
// Optional inter-position blanking is compiled in with SCAN_SEL_BLANK_EN.
module scan_sel_gen
    import scan_sel_gen_pkg::*;
#(
    parameter int DWELL_W   = DEF_DWELL_W,
    parameter int BLANK_CYC = DEF_BLANK_CYC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               sel_vld,
    output logic               busy,
    output logic               done
);

    scan_state_t        state_r;
    logic [1:0]         idx_r;
    logic               mode_r;
    logic [DWELL_W-1:0] dwell_r;

    logic               dwell_load_s;
    logic [DWELL_W-1:0] dwell_val_s;
    logic               dwell_dec_s;
    logic               dwell_zero_s;
    logic               last_s;

    assign last_s      = mode_r && (idx_r == LAST_POS);
    assign dwell_dec_s = (state_r == ST_SHOW);

`ifdef SCAN_SEL_BLANK_EN
    localparam int BLANK_W = $clog2(BLANK_CYC + 1);

    logic blank_load_s;
    logic blank_dec_s;
    logic blank_zero_s;
`else
    logic unused_cfg_s;
    assign unused_cfg_s = ^BLANK_CYC;
`endif

    // Counter load/decrement control derived from the current state.
    always_comb begin
        dwell_load_s = 1'b0;
        dwell_val_s  = dwell_r;
`ifdef SCAN_SEL_BLANK_EN
        blank_load_s = 1'b0;
        blank_dec_s  = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    dwell_load_s = 1'b1;
                    dwell_val_s  = dwell;
                end else begin
                    dwell_load_s = 1'b0;
                end
            end
            ST_SHOW: begin
                if (dwell_zero_s && !last_s) begin
`ifdef SCAN_SEL_BLANK_EN
                    blank_load_s = 1'b1;
`else
                    dwell_load_s = 1'b1;
`endif
                end else begin
                    dwell_load_s = 1'b0;
                end
            end
`ifdef SCAN_SEL_BLANK_EN
            ST_BLANK: begin
                if (blank_zero_s) begin
                    dwell_load_s = 1'b1;
                end else begin
                    blank_dec_s = 1'b1;
                end
            end
`endif
            default: dwell_load_s = 1'b0;
        endcase
    end

    scan_dwell_cnt #(.W(DWELL_W)) u_dwell_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dwell_load_s),
        .load_val (dwell_val_s),
        .dec      (dwell_dec_s),
        .zero     (dwell_zero_s)
    );

`ifdef SCAN_SEL_BLANK_EN
    scan_dwell_cnt #(.W(BLANK_W)) u_blank_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (blank_load_s),
        .load_val (BLANK_W'(BLANK_CYC - 1)),
        .dec      (blank_dec_s),
        .zero     (blank_zero_s)
    );
`endif

    // Sequencer FSM with registered select, qualifier and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= 2'd0;
            mode_r  <= 1'b0;
            dwell_r <= {DWELL_W{1'b0}};
            a       <= 1'b0;
            b       <= 1'b0;
            sel_vld <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state_r <= ST_SHOW;
                        mode_r  <= mode;
                        dwell_r <= dwell;
                        idx_r   <= 2'd0;
                        {a, b}  <= 2'd0;
                        sel_vld <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHOW: begin
                    if (stop) begin
                        state_r <= ST_IDLE;
                        idx_r   <= 2'd0;
                        {a, b}  <= 2'd0;
                        sel_vld <= 1'b0;
                        busy    <= 1'b0;
                    end else if (dwell_zero_s) begin
                        if (last_s) begin
                            state_r <= ST_IDLE;
                            idx_r   <= 2'd0;
                            {a, b}  <= 2'd0;
                            sel_vld <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
`ifdef SCAN_SEL_BLANK_EN
                            state_r <= ST_BLANK;
                            sel_vld <= 1'b0;
`else
                            idx_r   <= idx_r + 2'd1;
                            {a, b}  <= idx_r + 2'd1;
`endif
                        end
                    end else begin
                        state_r <= ST_SHOW;
                    end
                end
`ifdef SCAN_SEL_BLANK_EN
                ST_BLANK: begin
                    if (stop) begin
                        state_r <= ST_IDLE;
                        idx_r   <= 2'd0;
                        {a, b}  <= 2'd0;
                        sel_vld <= 1'b0;
                        busy    <= 1'b0;
                    end else if (blank_zero_s) begin
                        state_r <= ST_SHOW;
                        idx_r   <= idx_r + 2'd1;
                        {a, b}  <= idx_r + 2'd1;
                        sel_vld <= 1'b1;
                    end else begin
                        state_r <= ST_BLANK;
                    end
                end
`endif
                default: begin
                    state_r <= ST_IDLE;
                    idx_r   <= 2'd0;
                    {a, b}  <= 2'd0;
                    sel_vld <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_sel_gen.sv
// Table-driven directed bench for scan_sel_gen; expectations adapt to SCAN_SEL_BLANK_EN.
module tb_scan_sel_gen;

    localparam int DWELL_W   = 8;
    localparam int BLANK_CYC = 2;
`ifdef SCAN_SEL_BLANK_EN
    localparam int GAP_CYC = BLANK_CYC;
`else
    localparam int GAP_CYC = 0;
`endif

    typedef struct {
        logic       start;
        logic       stop;
        logic       mode;
        logic [7:0] dwell;
        logic [4:0] exp;   // {a, b, sel_vld, busy, done}
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] dwell = 8'd0;
    logic       a, b, sel_vld, busy, done;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    scan_sel_gen #(.DWELL_W(DWELL_W), .BLANK_CYC(BLANK_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .dwell(dwell), .a(a), .b(b), .sel_vld(sel_vld), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic push(input logic st, input logic sp, input logic md, input logic [7:0] dw,
                        input logic [1:0] ab, input logic vld, input logic bsy, input logic dn);
        vec_t v;
        v.start = st; v.stop = sp; v.mode = md; v.dwell = dw;
        v.exp = {ab, vld, bsy, dn};
        vecs.push_back(v);
    endtask

    // Show rows for one position; idle inputs carry noise to prove mode/dwell are latched.
    task automatic gen_pos(input logic [1:0] pos, input int cnt);
        for (int k = 0; k < cnt; k++) push(1'b0, 1'b0, 1'b0, 8'd9, pos, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic gen_gap(input logic [1:0] pos);
        for (int k = 0; k < GAP_CYC; k++) push(1'b0, 1'b0, 1'b0, 8'd9, pos, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {a,b,vld,busy,done}=%b, expected %b", name, got, exp);
        end
    endtask

    initial begin
        // Single sweep, dwell=2
        push(1'b1, 1'b0, 1'b1, 8'd2, 2'd0, 1'b1, 1'b1, 1'b0);
        gen_pos(2'd0, 2); gen_gap(2'd0);
        gen_pos(2'd1, 3); gen_gap(2'd1);
        gen_pos(2'd2, 3); gen_gap(2'd2);
        gen_pos(2'd3, 3);
        push(1'b0, 1'b0, 1'b0, 8'd9, 2'd0, 1'b0, 1'b0, 1'b1);
        push(1'b0, 1'b0, 1'b0, 8'd9, 2'd0, 1'b0, 1'b0, 1'b0);
        // Continuous, dwell=0, then stop
        push(1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        gen_gap(2'd0);
        for (int i = 1; i < 10; i++) begin
            gen_pos(2'(i % 4), 1);
            gen_gap(2'(i % 4));
        end
        push(1'b0, 1'b1, 1'b0, 8'd9, 2'd0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 8'd9, 2'd0, 1'b0, 1'b0, 1'b0);
        // Stop during position 2 of a single sweep
        push(1'b1, 1'b0, 1'b1, 8'd2, 2'd0, 1'b1, 1'b1, 1'b0);
        gen_pos(2'd0, 2); gen_gap(2'd0);
        gen_pos(2'd1, 3); gen_gap(2'd1);
        gen_pos(2'd2, 1);
        push(1'b0, 1'b1, 1'b0, 8'd9, 2'd0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 8'd9, 2'd0, 1'b0, 1'b0, 1'b0);
        // start+stop together in IDLE
        push(1'b1, 1'b1, 1'b1, 8'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b1, 8'd3, 2'd0, 1'b0, 1'b0, 1'b0);
        // Single sweep dwell=1 with an ignored re-start while busy
        push(1'b1, 1'b0, 1'b1, 8'd1, 2'd0, 1'b1, 1'b1, 1'b0);
        push(1'b1, 1'b0, 1'b0, 8'd5, 2'd0, 1'b1, 1'b1, 1'b0);
        gen_gap(2'd0);
        gen_pos(2'd1, 2); gen_gap(2'd1);
        gen_pos(2'd2, 2); gen_gap(2'd2);
        gen_pos(2'd3, 2);
        push(1'b0, 1'b0, 1'b0, 8'd9, 2'd0, 1'b0, 1'b0, 1'b1);
        // Start in the done cycle, single sweep dwell=0
        push(1'b1, 1'b0, 1'b1, 8'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        gen_gap(2'd0);
        gen_pos(2'd1, 1); gen_gap(2'd1);
        gen_pos(2'd2, 1); gen_gap(2'd2);
        gen_pos(2'd3, 1);
        push(1'b0, 1'b0, 1'b0, 8'd9, 2'd0, 1'b0, 1'b0, 1'b1);
        push(1'b0, 1'b0, 1'b0, 8'd9, 2'd0, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        check("reset_state", {a, b, sel_vld, busy, done}, 5'b00000);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            start = vecs[i].start; stop = vecs[i].stop;
            mode  = vecs[i].mode;  dwell = vecs[i].dwell;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", i), {a, b, sel_vld, busy, done}, vecs[i].exp);
        end

        // Asynchronous reset in the middle of a continuous scan
        start = 1'b1; mode = 1'b0; dwell = 8'd0; stop = 1'b0;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        check("pre_reset_running", {busy, done}, {1'b1, 1'b0});
        #2 rst_n = 1'b0;
        #1 check("async_reset", {a, b, sel_vld, busy, done}, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("post_reset_idle", {a, b, sel_vld, busy, done}, 5'b00000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
